// File: rtl/param_tff_counter.sv
`default_nettype none
// ============================================================================
//  Module   : param_tff_counter
//  Brief    : WIDTH-bit modulo-MODULUS up/down counter with prescaler, load,
//             wrap/saturate mode, terminal-count pulse, sticky overflow and
//             active-low 7-segment hex readout.
//  Revision : 1.0 - initial release
// ============================================================================
module param_tff_counter #(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 256,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0,
  parameter int NDIG     = (WIDTH + 3) / 4
) (
  input  logic              CLOCK,
  input  logic              CLEAR,
  input  logic              ENABLE,
  input  logic              UP,
  input  logic              LOAD,
  input  logic [WIDTH-1:0]  LOAD_VALUE,
  input  logic              ACK_OVF,
  output logic [WIDTH-1:0]  Q,
  output logic              TC,
  output logic              OVF,
  output logic [7*NDIG-1:0] HEX
);

  localparam int               c_PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_PW-1:0]  c_PRE_MAX  = c_PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] c_Q_MAX    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   c_MOD      = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] r_q;
  logic [c_PW-1:0]  r_p;
  logic             r_tc;
  logic             r_ovf;

  logic             w_step;
  logic             w_bound;
  logic [WIDTH-1:0] w_q_step;
  logic [WIDTH-1:0] w_q_load;

  always_comb begin
    w_step   = ENABLE && (r_p == c_PRE_MAX);
    w_bound  = w_step && (UP ? (r_q == c_Q_MAX) : (r_q == '0));
    w_q_load = ({1'b0, LOAD_VALUE} < c_MOD) ? LOAD_VALUE : c_Q_MAX;
    w_q_step = r_q;
    if (UP) begin
      if (r_q != c_Q_MAX)    w_q_step = r_q + 1'b1;
      else if (SATURATE == 0) w_q_step = '0;
    end else begin
      if (r_q != '0)          w_q_step = r_q - 1'b1;
      else if (SATURATE == 0) w_q_step = c_Q_MAX;
    end
  end

  always_ff @(posedge CLOCK or posedge CLEAR) begin
    if (CLEAR) begin
      r_q   <= '0;
      r_p   <= '0;
      r_tc  <= 1'b0;
      r_ovf <= 1'b0;
    end else if (LOAD) begin
      r_q  <= w_q_load;
      r_p  <= '0;
      r_tc <= 1'b0;
      if (ACK_OVF) r_ovf <= 1'b0;
    end else begin
      r_tc <= w_bound;
      if (ENABLE) r_p <= (r_p == c_PRE_MAX) ? '0 : r_p + 1'b1;
      if (w_step) r_q <= w_q_step;
      // a boundary event on the same edge as an acknowledge keeps the flag set
      if (w_bound)      r_ovf <= 1'b1;
      else if (ACK_OVF) r_ovf <= 1'b0;
    end
  end

  assign Q   = r_q;
  assign TC  = r_tc;
  assign OVF = r_ovf;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // top nibble is zero-extended when WIDTH is not a multiple of four
  logic [4*NDIG-1:0] w_qpad;
  assign w_qpad = (4*NDIG)'(r_q);

  for (genvar k = 0; k < NDIG; k++) begin : g_dig
    assign HEX[7*k +: 7] = seg7(w_qpad[4*k +: 4]);
  end

endmodule
`default_nettype wire

// File: doc/param_tff_counter.md
Name: param_tff_counter

Overview:
Parametrised successor to the 8-bit enable/clear counter with hex readout. It is a WIDTH-bit modulo-MODULUS up/down counter with a built-in prescaler, synchronous load, wrap or saturate mode, a terminal-count pulse and a sticky overflow flag. It also drives a 7-segment bus with one hex digit per nibble of the count. It sits between board switches/keys and the HEX displays, and serves as the reusable counter/timer for later labs.

Parameters:
WIDTH, 8, count register width in bits (>=1)
MODULUS, 256, count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2^WIDTH
PRESCALE, 1, number of enabled cycles per count step; 1 = step every enabled cycle; prescaler width = max(1, clog2(PRESCALE))
SATURATE, 0, 0 = wrap at the boundaries, 1 = hold at the boundaries
NDIG, ceil(WIDTH/4), number of hex digits driven

Ports:
CLOCK  in  1  rising-edge clock
CLEAR  in  1  asynchronous reset, active-high
ENABLE  in  1  count enable; gates both the prescaler and stepping
UP  in  1  direction: 1 = up, 0 = down; sampled on the step cycle
LOAD  in  1  synchronous load
LOAD_VALUE  in  WIDTH  value to load
ACK_OVF  in  1  clears the sticky OVF flag
Q  out  WIDTH  current count (registered)
TC  out  1  terminal-count pulse (registered)
OVF  out  1  sticky overflow flag (registered)
HEX  out  7*NDIG  segments for digit k at HEX[7k+6:7k]; bit0 = segment a ... bit6 = segment g; active-low

Behaviour:
- CLEAR=1, asynchronous and immediate: Q=0, prescaler=0, TC=0, OVF=0. Held while CLEAR=1.
- Priority at each rising edge: CLEAR > LOAD > step.
- LOAD=1:
  - Q <= LOAD_VALUE if LOAD_VALUE < MODULUS, else Q <= MODULUS-1 (clamp).
  - Prescaler <= 0.
  - TC <= 0 and OVF is unchanged (ACK_OVF is still honoured).
  - Acts regardless of ENABLE.
- Prescaler p (LOAD=0):
  - ENABLE=0: p and Q hold; TC <= 0.
  - ENABLE=1 and p < PRESCALE-1: p <= p+1, no step.
  - ENABLE=1 and p == PRESCALE-1: p <= 0, and this is a step cycle.
- Step, up (UP=1):
  - Q < MODULUS-1: Q <= Q+1.
  - Q == MODULUS-1: boundary event; Q <= 0 (SATURATE=0) or Q holds (SATURATE=1).
- Step, down (UP=0):
  - Q > 0: Q <= Q-1.
  - Q == 0: boundary event; Q <= MODULUS-1 (SATURATE=0) or Q holds (SATURATE=1).
- Arithmetic: done at WIDTH bits. No out-of-range Q is reachable except via the clamp, which prevents it.
- TC: 1 for exactly the one cycle following a boundary-event edge, otherwise 0. Consecutive boundary events in saturate mode with PRESCALE=1 keep TC high continuously.
- OVF:
  - Set on a boundary-event edge.
  - Cleared on an edge with ACK_OVF=1.
  - If both happen on the same edge, the set wins.
- Latency: Q, TC and OVF change on the same rising edge as the step or load. HEX is combinational from Q (zero additional cycles).
- HEX digit k shows Q[4k+3:4k]; the top digit is zero-extended when WIDTH is not a multiple of 4.
  - Glyphs: 0-9, A, b, C, d, E, F.
  - Active-low encodings: 0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000, F = 7'b0001110.
- UP toggled mid-prescale: has no effect until the step cycle; p is not reset.
- CLEAR asserted mid-operation: discards the prescaler phase. After release, counting restarts from p=0 and a full PRESCALE enabled cycles are needed before the first step.

Test Plan:
1. Reset: defaults, count to Q=0x37, assert CLEAR between edges -> Q=0x00, TC=0, OVF=0 immediately; HEX[6:0]=HEX[13:7]=7'b1000000.
2. Up wrap: MODULUS=10, PRESCALE=1, UP=1, ENABLE=1 from 0 -> Q=9 after 9 edges; 10th edge gives Q=0, TC=1 for one cycle, OVF=1. Then ACK_OVF pulse -> OVF=0.
3. Down saturate: SATURATE=1, load 2, UP=0 -> Q=1, 0, 0. TC=1 only after the third step. OVF=1.
4. Prescale: PRESCALE=4, ENABLE=1 -> Q steps on edges 4, 8, 12. Deasserting ENABLE for 3 cycles after edge 5 moves the next step to edge 11.
5. Load clamp/priority: MODULUS=10, LOAD=1 with LOAD_VALUE=15 and ENABLE=1 on a step cycle -> Q=9, TC=0, p=0. Next step (UP=1) wraps to 0 with TC=1.
6. Simultaneous set/clear: OVF=1, ACK_OVF=1 on the same edge as a wrap -> OVF stays 1. ACK_OVF on the next non-event edge -> OVF=0.
